// File: rtl/riscv_defines.sv
// Shared constants and boot-loader state encoding for the
// instruction ROM and the core it feeds.
package riscv_defines;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/rom_array.sv
// DEPTHx32 instruction array: one synchronous write port,
// one combinational read port.
module rom_array #(
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_boot.sv
// Boot-loaded instruction memory: assembles a little-endian byte
// stream into words and holds the core in reset until loading ends.
module inst_rom_boot #(
    parameter int          DEPTH    = 4096,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    input  logic        reload_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_o,
    output logic        core_rst_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    import riscv_defines::*;

    localparam int AW = $clog2(DEPTH);

    state_t        state;
    logic [1:0]    lane;
    logic [23:0]   hold;
    logic [AW-1:0] widx;
    logic [AW:0]   n_words;
    logic [AW:0]   loaded;
    logic          core_rst;
    logic          done;
    logic          err;

    logic          fire;
    logic          last;
    logic          we;
    logic [31:0]   word;
    logic [31:0]   rdata;
    logic [AW-1:0] ridx;
    logic          out_of_range;
    logic          unused_addr;

    assign byte_ready_o = (state == S_LEN) || (state == S_DATA);
    assign fire         = byte_valid_i & byte_ready_o;
    assign last         = fire && (lane == 2'd3);
    assign word         = {byte_data_i, hold};
    assign we           = last && (state == S_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_LEN;
            lane     <= '0;
            hold     <= '0;
            widx     <= '0;
            n_words  <= '0;
            loaded   <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (fire) begin
                lane <= lane + 2'd1;
                case (lane)
                    2'd0:    hold[7:0]   <= byte_data_i;
                    2'd1:    hold[15:8]  <= byte_data_i;
                    2'd2:    hold[23:16] <= byte_data_i;
                    default: ;
                endcase
            end
            unique case (state)
                S_LEN: begin
                    if (last) begin
                        if (word == 32'd0) begin
                            state    <= S_RUN;
                            loaded   <= '0;
                            core_rst <= 1'b0;
                            done     <= 1'b1;
                        end else if (word > 32'(DEPTH)) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else begin
                            n_words <= word[AW:0];
                            widx    <= '0;
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (last) begin
                        widx <= widx + AW'(1);
                        // final word: release the core on this same edge
                        if ({1'b0, widx} == n_words - (AW+1)'(1)) begin
                            state    <= S_RUN;
                            loaded   <= n_words;
                            core_rst <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                S_RUN, S_ERR: begin
                    if (reload_i) begin
                        state    <= S_LEN;
                        lane     <= '0;
                        widx     <= '0;
                        loaded   <= '0;
                        core_rst <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_rst_o  = core_rst;
    assign load_done_o = done;
    assign load_err_o  = err;

    rom_array #(
        .DEPTH(DEPTH)
    ) u_rom (
        .clk  (clk),
        .we   (we),
        .waddr(widx),
        .wdata(word),
        .raddr(ridx),
        .rdata(rdata)
    );

    // stale words beyond the loaded count must never reach the core
    assign ridx         = inst_addr_i[AW+1:2];
    assign out_of_range = (|inst_addr_i[31:AW+2]) ||
                          ({1'b0, ridx} >= loaded);
    assign inst_o       = out_of_range ? NOP_INST : rdata;
    assign unused_addr  = ^inst_addr_i[1:0];

endmodule

// File: tb/tb_inst_rom_boot.sv
// Self-checking bench for inst_rom_boot: directed loads, read
// tables and randomized loads against a word-list model.
module tb_inst_rom_boot;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        reload;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        core_rst;
    logic        load_done;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] prog[$];
    int          loaded_n = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t tab[6];

    inst_rom_boot dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid_i(byte_valid),
        .byte_data_i (byte_data),
        .byte_ready_o(byte_ready),
        .reload_i    (reload),
        .inst_addr_i (inst_addr),
        .inst_o      (inst),
        .core_rst_o  (core_rst),
        .load_done_o (load_done),
        .load_err_o  (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int idx;
        idx = int'(a[13:2]);
        if (a[31:14] != 0 || idx >= loaded_n) return NOP;
        return prog[idx];
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], $urandom_range(gmax, 0));
    endtask

    task automatic load(input int n, input int gmax);
        logic [31:0] h;
        h = n;
        send_word(h, gmax);
        for (int w = 0; w < n; w++) send_word(prog[w], gmax);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a,
                      input logic [31:0] exp);
        @(negedge clk);
        inst_addr = a;
        #1;
        chk(nm, inst, exp);
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = '0;
        reload     = 1'b0;
        inst_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_core_rst", 32'(core_rst), 1);
        chk("rst_ready", 32'(byte_ready), 1);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_err", 32'(load_err), 0);
        chk("rst_inst", inst, NOP);
        @(negedge clk);
        rst = 1'b0;

        // N=3 with the core release edge observed
        prog = '{32'h00100513, 32'h00200593, 32'h00b50633};
        send_word(32'd3, 0);
        send_word(prog[0], 0);
        send_word(prog[1], 0);
        send_byte(8'h33, 0);
        send_byte(8'h06, 0);
        send_byte(8'hb5, 0);
        chk("n3_core_rst_before", 32'(core_rst), 1);
        chk("n3_done_before", 32'(load_done), 0);
        send_byte(8'h00, 0);
        loaded_n = 3;
        chk("n3_core_rst_after", 32'(core_rst), 0);
        chk("n3_done_after", 32'(load_done), 1);
        chk("n3_ready_after", 32'(byte_ready), 0);
        tab[0] = '{32'h0, 32'h00100513};
        tab[1] = '{32'h4, 32'h00200593};
        tab[2] = '{32'h8, 32'h00b50633};
        tab[3] = '{32'hc, NOP};
        tab[4] = '{32'h6, 32'h00200593};
        tab[5] = '{32'h0001_0000, NOP};
        for (int i = 0; i < 6; i++)
            rd($sformatf("n3_tab%0d", i), tab[i].addr, tab[i].exp);

        // empty program
        do_reload();
        chk("rl_ready", 32'(byte_ready), 1);
        chk("rl_core_rst", 32'(core_rst), 1);
        rd("rl_inst0", 32'h0, NOP);
        send_word(32'd0, 0);
        loaded_n = 0;
        chk("n0_done", 32'(load_done), 1);
        chk("n0_core_rst", 32'(core_rst), 0);
        chk("n0_ready", 32'(byte_ready), 0);
        rd("n0_inst0", 32'h0, NOP);
        rd("n0_inst4", 32'h4, NOP);
        send_byte(8'haa, 0);
        chk("n0_ignored_done", 32'(load_done), 1);
        chk("n0_ignored_ready", 32'(byte_ready), 0);

        // oversize header
        do_reload();
        send_word(32'(DEPTH + 1), 0);
        chk("err_flag", 32'(load_err), 1);
        chk("err_core_rst", 32'(core_rst), 1);
        chk("err_ready", 32'(byte_ready), 0);
        chk("err_done", 32'(load_done), 0);
        do_reload();
        chk("err_rl_ready", 32'(byte_ready), 1);
        chk("err_rl_err", 32'(load_err), 0);

        // gapped delivery, garbage on the bus while valid is low
        prog = '{32'h11223344, 32'h55667788};
        load(2, 3);
        loaded_n = 2;
        chk("gap_done", 32'(load_done), 1);
        rd("gap_w0", 32'h0, 32'h11223344);
        rd("gap_w1", 32'h4, 32'h55667788);
        rd("gap_w2", 32'h8, NOP);

        // reset mid-load
        do_reload();
        send_word(32'd2, 0);
        send_word(32'hcafef00d, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        loaded_n = 0;
        chk("mid_rst_core_rst", 32'(core_rst), 1);
        chk("mid_rst_ready", 32'(byte_ready), 1);
        chk("mid_rst_done", 32'(load_done), 0);
        rd("mid_rst_inst0", 32'h0, NOP);
        @(negedge clk);
        rst = 1'b0;
        prog = '{32'hdeadbeef};
        load(1, 0);
        loaded_n = 1;
        rd("fresh_w0", 32'h0, 32'hdeadbeef);
        rd("fresh_w1", 32'h4, NOP);

        // above-array address, then shorter reload hides stale word
        prog = '{32'h0badf00d, 32'h12345678};
        do_reload();
        load(2, 1);
        loaded_n = 2;
        rd("hi_addr", 32'h0001_0000, NOP);
        rd("n2_w1", 32'h4, 32'h12345678);
        prog = '{32'h00000093};
        do_reload();
        load(1, 0);
        loaded_n = 1;
        rd("short_w0", 32'h0, 32'h00000093);
        rd("short_stale", 32'h4, NOP);

        // full-depth boundary load
        prog.delete();
        for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
        do_reload();
        load(DEPTH, 0);
        loaded_n = DEPTH;
        chk("full_done", 32'(load_done), 1);
        rd("full_first", 32'h0, prog[0]);
        rd("full_last", 32'((DEPTH - 1) * 4), prog[DEPTH-1]);
        rd("full_wrap", 32'(DEPTH * 4), NOP);

        // randomized loads against the model
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(24, 1);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            do_reload();
            loaded_n = 0;
            load(n, 2);
            loaded_n = n;
            chk($sformatf("rnd%0d_done", r), 32'(load_done), 1);
            for (int k = 0; k < 12; k++) begin
                logic [31:0] a;
                a = 32'($urandom_range(127, 0));
                if ($urandom_range(7, 0) == 0)
                    a = a | (32'h0000_4000 << $urandom_range(17, 0));
                rd($sformatf("rnd%0d_rd%0d", r, k), a, model_rd(a));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
